// File: rtl/bbox_sample_iter.sv
// bbox_sample_iter
//   Sample iterator between the bounding-box stage and the hash stage.
//   Accepts one triangle plus its step-aligned bounding box per handshake,
//   then walks every sample position in the box in raster order (x fastest),
//   one sample per cycle, forwarding triangle and color with each sample.
//   Upstream is held (halt_RnnnnL low) for the whole walk.
//
// Ports
//   clk, rst           : clock (rising edge), synchronous active-high reset
//   tri_R13S           : input triangle vertices, VERTS*AXIS*SIGFIG
//   color_R13U         : input triangle color, COLORS*SIGFIG
//   box_R13S           : bounding box {ll.x, ll.y, ur.x, ur.y}, step aligned
//   validTri_R13H      : input triangle valid
//   subSample_RnnnnU   : one-hot rate 1000=1x 0100=2x2 0010=4x4 0001=8x8
//   halt_RnnnnL        : low while walking; upstream must hold
//   tri_R14S/color_R14U: forwarded triangle/color
//   sample_R14S        : sample {x, y}
//   validSamp_R14H     : sample valid
//   sampCount_RnnnnU   : (ITER_SAMPLE_COUNT_EN only) running count of valid
//                        sample cycles, wraps modulo 2^32
//
// Optional feature macro: ITER_SAMPLE_COUNT_EN

module bbox_sample_iter #(
  parameter int SIGFIG     = 24,
  parameter int RADIX      = 10,
  parameter int VERTS      = 3,
  parameter int AXIS       = 3,
  parameter int COLORS     = 3,
  parameter int PIPES_ITER = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [VERTS*AXIS*SIGFIG-1:0]    tri_R13S,
  input  logic [COLORS*SIGFIG-1:0]        color_R13U,
  input  logic [2*2*SIGFIG-1:0]           box_R13S,
  input  logic                            validTri_R13H,
  input  logic [3:0]                      subSample_RnnnnU,
  output logic                            halt_RnnnnL,
  output logic [VERTS*AXIS*SIGFIG-1:0]    tri_R14S,
  output logic [COLORS*SIGFIG-1:0]        color_R14U,
  output logic [2*SIGFIG-1:0]             sample_R14S,
  output logic                            validSamp_R14H
`ifdef ITER_SAMPLE_COUNT_EN
  ,
  output logic [31:0]                     sampCount_RnnnnU
`endif
);

  // Only a single-stage iterator is implemented.
  if (PIPES_ITER != 1) begin : g_bad_pipes
    $error("bbox_sample_iter: PIPES_ITER must be 1");
  end

  typedef enum logic {S_WAIT = 1'b0, S_TEST = 1'b1} state_t;

  localparam logic [SIGFIG:0] STEP_1X = (SIGFIG+1)'(1) << RADIX;

  state_t                         r_state;
  logic [VERTS*AXIS*SIGFIG-1:0]   r_tri;
  logic [COLORS*SIGFIG-1:0]       r_color;
  logic [SIGFIG-1:0]              r_llx, r_urx, r_ury;
  logic [SIGFIG-1:0]              r_x, r_y;
  logic                           r_valid;

  logic [SIGFIG:0]                w_step;
  logic [SIGFIG:0]                w_nx, w_ny;
  logic                           w_x_ok, w_y_ok;

  // Step decode from the one-hot rate; unexpected codes fall back to 1x.
  always_comb begin
    w_step = STEP_1X;
    case (subSample_RnnnnU)
      4'b1000: w_step = STEP_1X;
      4'b0100: w_step = STEP_1X >> 1;
      4'b0010: w_step = STEP_1X >> 2;
      4'b0001: w_step = STEP_1X >> 3;
      default: w_step = STEP_1X;
    endcase
  end

  // Next-position sums carried at SIGFIG+1 bits so a box hugging full scale
  // cannot wrap and compare as smaller than ur.
  always_comb begin
    w_nx   = {r_x[SIGFIG-1], r_x} + w_step;
    w_ny   = {r_y[SIGFIG-1], r_y} + w_step;
    w_x_ok = $signed(w_nx) <= $signed({r_urx[SIGFIG-1], r_urx});
    w_y_ok = $signed(w_ny) <= $signed({r_ury[SIGFIG-1], r_ury});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_tri   <= '0;
      r_color <= '0;
      r_llx   <= '0;
      r_urx   <= '0;
      r_ury   <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (validTri_R13H) begin
            r_tri   <= tri_R13S;
            r_color <= color_R13U;
            r_llx   <= box_R13S[4*SIGFIG-1:3*SIGFIG];
            r_urx   <= box_R13S[2*SIGFIG-1:1*SIGFIG];
            r_ury   <= box_R13S[1*SIGFIG-1:0];
            r_x     <= box_R13S[4*SIGFIG-1:3*SIGFIG];
            r_y     <= box_R13S[3*SIGFIG-1:2*SIGFIG];
            r_valid <= 1'b1;
            r_state <= S_TEST;
          end else begin
            r_valid <= 1'b0;
          end
        end
        S_TEST: begin
          // Inputs are ignored here; upstream is held by halt_RnnnnL.
          if (w_x_ok) begin
            r_x <= w_nx[SIGFIG-1:0];
          end else if (w_y_ok) begin
            r_x <= r_llx;
            r_y <= w_ny[SIGFIG-1:0];
          end else begin
            // Last sample of the box is on the output now; one bubble follows.
            r_state <= S_WAIT;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_WAIT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign halt_RnnnnL    = (r_state == S_WAIT);
  assign tri_R14S       = r_tri;
  assign color_R14U     = r_color;
  assign sample_R14S    = {r_x, r_y};
  assign validSamp_R14H = r_valid;

`ifdef ITER_SAMPLE_COUNT_EN
  logic [31:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + 32'(r_valid);
  end

  assign sampCount_RnnnnU = r_cnt;
`endif

endmodule

// File: tb/tb_bbox_sample_iter.sv
// Testbench for bbox_sample_iter: directed scenarios plus randomized
// triangles, each cycle compared against a queue-based reference model that
// expands every accepted box into its full list of sample positions.

module tb_bbox_sample_iter;

  localparam int TW = 216;
  localparam int CW = 72;

  logic            clk = 1'b0;
  logic            rst;
  logic [TW-1:0]   tri_i;
  logic [CW-1:0]   col_i;
  logic [95:0]     box_i;
  logic            vld_i;
  logic [3:0]      sub_i;
  logic            halt_o;
  logic [TW-1:0]   tri_o;
  logic [CW-1:0]   col_o;
  logic [47:0]     samp_o;
  logic            vsamp_o;
`ifdef ITER_SAMPLE_COUNT_EN
  logic [31:0]     cnt_o;
`endif

  bbox_sample_iter dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_i),
    .color_R13U       (col_i),
    .box_R13S         (box_i),
    .validTri_R13H    (vld_i),
    .subSample_RnnnnU (sub_i),
    .halt_RnnnnL      (halt_o),
    .tri_R14S         (tri_o),
    .color_R14U       (col_o),
    .sample_R14S      (samp_o),
    .validSamp_R14H   (vsamp_o)
`ifdef ITER_SAMPLE_COUNT_EN
    ,
    .sampCount_RnnnnU (cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [47:0]     q[$];
  logic [TW-1:0]   m_tri;
  logic [CW-1:0]   m_col;
  logic [31:0]     m_cnt;
  int              n_cmp = 0;
  int              n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input logic [3:0] s);
    int k;
    k = 0;
    for (int i = 0; i < 4; i++) if (s[3-i]) k = i;
    return 1 << (10 - k);
  endfunction

  function automatic logic [95:0] mkbox(input int llx, input int lly, input int urx, input int ury);
    return {llx[23:0], lly[23:0], urx[23:0], ury[23:0]};
  endfunction

  // Expand the box on the inputs into raster-ordered samples.
  task automatic fill();
    int llx, lly, urx, ury, st;
    llx = int'($signed(box_i[95:72]));
    lly = int'($signed(box_i[71:48]));
    urx = int'($signed(box_i[47:24]));
    ury = int'($signed(box_i[23:0]));
    st  = step_of(sub_i);
    for (int y = lly; y <= ury; y += st)
      for (int x = llx; x <= urx; x += st)
        q.push_back({x[23:0], y[23:0]});
    m_tri = tri_i;
    m_col = col_i;
  endtask

  // One clock: advance model on the edge, then compare #1 later.
  task automatic cyc();
    logic was_rst;
    @(posedge clk);
    was_rst = rst;
    if (rst) begin
      m_cnt = '0;
      q.delete();
    end else begin
      if (q.size() > 0) m_cnt = m_cnt + 32'd1;
      if (q.size() == 0) begin
        if (vld_i) fill();
      end else begin
        void'(q.pop_front());
      end
    end
    #1;
    chk("halt",  256'(halt_o),  256'(q.size() == 0));
    chk("valid", 256'(vsamp_o), 256'(q.size() > 0));
    if (q.size() > 0) begin
      chk("sample", 256'(samp_o), 256'(q[0]));
      chk("tri",    256'(tri_o),  256'(m_tri));
      chk("color",  256'(col_o),  256'(m_col));
    end
    if (was_rst) begin
      chk("rst_sample", 256'(samp_o), 256'(0));
      chk("rst_tri",    256'(tri_o),  256'(0));
      chk("rst_color",  256'(col_o),  256'(0));
    end
`ifdef ITER_SAMPLE_COUNT_EN
    chk("count", 256'(cnt_o), 256'(m_cnt));
`endif
  endtask

  task automatic rand_payload();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
    tri_i = t[TW-1:0];
    col_i = t[CW+99:100];
  endtask

  // Present one triangle, pulse valid, walk it out plus the bubble.
  task automatic run_tri(input logic [95:0] b, input logic [3:0] s);
    rand_payload();
    box_i = b;
    sub_i = s;
    vld_i = 1'b1;
    cyc();
    vld_i = 1'b0;
    rand_payload();
    for (int i = 0; i < 200 && q.size() > 0; i++) cyc();
    cyc();
  endtask

  logic [3:0] sub_tab [4];

  initial begin
    sub_tab = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    m_cnt = '0;
    rst   = 1'b1;
    vld_i = 1'b1;     // reset must win over a valid triangle
    sub_i = 4'b1000;
    box_i = mkbox(0, 0, 1024, 1024);
    rand_payload();
    cyc();
    cyc();
    rst   = 1'b0;
    vld_i = 1'b0;
    cyc();

    // 1x walk and 4x4 rate
    run_tri(mkbox(0, 0, 2048, 1024), 4'b1000);
    run_tri(mkbox(0, 0, 256, 256), 4'b0010);
`ifdef ITER_SAMPLE_COUNT_EN
    chk("count_after_two", 256'(cnt_o), 256'(10));
`endif

    // Degenerate and negative boxes
    run_tri(mkbox(512, 512, 512, 512), 4'b1000);
    run_tri(mkbox(-1024, -1024, 0, -1024), 4'b1000);

    // Full-scale edges: next position would overflow 24 bits
    run_tri(mkbox(8386560, 8386560, 8387584, 8387584), 4'b1000);
    run_tri(mkbox(-8388608, -8388608, -8387584, -8388608), 4'b0001);

    // Back-to-back with valid held high, two 2-sample boxes
    rand_payload();
    sub_i = 4'b0100;
    box_i = mkbox(0, 0, 512, 0);
    vld_i = 1'b1;
    cyc();
    rand_payload();
    box_i = mkbox(-512, 1024, -512, 1536);
    cyc();
    cyc();
    cyc();
    vld_i = 1'b0;
    cyc();
    cyc();
    cyc();

    // Reset after the 2nd sample of a 6-sample box
    rand_payload();
    sub_i = 4'b1000;
    box_i = mkbox(0, 0, 2048, 1024);
    vld_i = 1'b1;
    cyc();
    vld_i = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    run_tri(mkbox(3072, -2048, 4096, -1024), 4'b1000);

    // Randomized triangles, sometimes with valid kept high into the bubble
    for (int n = 0; n < 40; n++) begin
      int st, llx, lly;
      logic [3:0] s;
      s   = sub_tab[$urandom_range(0, 3)];
      st  = step_of(s);
      llx = (int'($urandom_range(0, 16)) - 8) * st;
      lly = (int'($urandom_range(0, 16)) - 8) * st;
      rand_payload();
      sub_i = s;
      box_i = mkbox(llx, lly, llx + int'($urandom_range(0, 5)) * st,
                    lly + int'($urandom_range(0, 4)) * st);
      vld_i = 1'b1;
      cyc();
      vld_i = ($urandom_range(0, 3) == 0);
      rand_payload();
      for (int i = 0; i < 200 && q.size() > 0; i++) cyc();
      vld_i = 1'b0;
      cyc();
      if (q.size() > 0) begin
        for (int i = 0; i < 200 && q.size() > 0; i++) cyc();
        cyc();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
